// File: rtl/noc_pkg.sv
// ============================================================================
// Package  : noc_pkg
// Purpose  : Shared packet width, header field positions and one-hot route
//            codes for the mesh router.
// Revision : 1.0
// ============================================================================
`default_nettype none

package noc_pkg;

  localparam int DATA_W = 64;

  // Header field positions
  localparam int VC_BIT = 63;
  localparam int DX_BIT = 62;  // 0 = east, 1 = west
  localparam int DY_BIT = 61;  // 0 = north, 1 = south
  localparam int HX_MSB = 55;
  localparam int HX_LSB = 52;
  localparam int HY_MSB = 51;
  localparam int HY_LSB = 48;

  // One-hot switch request codes {L,W,E,S,N}
  localparam logic [4:0] ROUTE_N = 5'b00001;
  localparam logic [4:0] ROUTE_S = 5'b00010;
  localparam logic [4:0] ROUTE_E = 5'b00100;
  localparam logic [4:0] ROUTE_W = 5'b01000;
  localparam logic [4:0] ROUTE_L = 5'b10000;

endpackage

`default_nettype wire

// File: rtl/router_vc_fifo.sv
// ============================================================================
// Module   : router_vc_fifo
// Purpose  : One virtual-channel buffer: DEPTH-entry circular FIFO with a
//            combinational head output and storage cleared on reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module router_vc_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  // A one-entry FIFO still gets a 1-bit pointer; it simply never leaves 0.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  // Guard locally so a misbehaving caller cannot corrupt the count.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state pointers and occupancy, wrapping modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; zeroed on reset so the idle head reads as 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/router_input_channel.sv
// ============================================================================
// Module   : router_input_channel
// Purpose  : Per-port router input stage. Buffers link packets into two
//            VCs chosen by polarity, offers the opposite VC's head to the
//            switch with an XY route request, pops on grant.
// Options  : ROUTE_HOP_DEC_EN - sw_data carries the routed dimension's hop
//            count already decremented (stored data untouched).
// Revision : 1.0
// ============================================================================
`default_nettype none

module router_input_channel #(
  parameter int DATA_W = noc_pkg::DATA_W,
  parameter int DEPTH  = 2,
  parameter int HOP_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              link_send_in,
  input  logic [DATA_W-1:0] link_data_in,
  output logic              link_ready_out,
  output logic              sw_req,
  output logic [4:0]        sw_route,
  output logic [DATA_W-1:0] sw_data,
  input  logic              sw_grant,
  output logic              overflow_err
);

  import noc_pkg::*;

  logic              full0, full1, empty0, empty1;
  logic [DATA_W-1:0] head0, head1, rd_head;
  logic              push_ok, pop_ok;
  logic              push0, push1, pop0, pop1;
  logic [HOP_W-1:0]  hx, hy;
  logic              overflow_q, overflow_d;

  // polarity=1: VC0 written, VC1 read; polarity=0: the reverse.
  assign link_ready_out = polarity ? !full0 : !full1;
  assign sw_req         = polarity ? !empty1 : !empty0;
  assign rd_head        = polarity ? head1 : head0;

  assign push_ok = link_send_in && link_ready_out;
  assign pop_ok  = sw_grant && sw_req;
  assign push0   = push_ok && polarity;
  assign push1   = push_ok && !polarity;
  assign pop0    = pop_ok && !polarity;
  assign pop1    = pop_ok && polarity;

  router_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_vc0 (
    .clk(clk), .reset(reset), .push(push0), .push_data(link_data_in),
    .pop(pop0), .full(full0), .empty(empty0), .head(head0)
  );

  router_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_vc1 (
    .clk(clk), .reset(reset), .push(push1), .push_data(link_data_in),
    .pop(pop1), .full(full1), .empty(empty1), .head(head1)
  );

  assign hx = rd_head[HX_LSB +: HOP_W];
  assign hy = rd_head[HY_LSB +: HOP_W];

  // XY dimension-order routing: finish X first, then Y, then eject locally.
  always_comb begin
    sw_route = 5'b0;
    if (sw_req) begin
      if (hx != '0)      sw_route = rd_head[DX_BIT] ? ROUTE_W : ROUTE_E;
      else if (hy != '0) sw_route = rd_head[DY_BIT] ? ROUTE_S : ROUTE_N;
      else               sw_route = ROUTE_L;
    end
  end

`ifdef ROUTE_HOP_DEC_EN
  // Output copy has the routed dimension's hop consumed; buffer is unchanged.
  always_comb begin
    sw_data = rd_head;
    if (sw_route == ROUTE_E || sw_route == ROUTE_W)
      sw_data[HX_LSB +: HOP_W] = hx - HOP_W'(1);
    else if (sw_route == ROUTE_N || sw_route == ROUTE_S)
      sw_data[HY_LSB +: HOP_W] = hy - HOP_W'(1);
  end
`else
  assign sw_data = rd_head;
`endif

  assign overflow_d = overflow_q || (link_send_in && !link_ready_out);

  // Sticky overflow flag: a send into a full write-VC is dropped and recorded.
  always_ff @(posedge clk) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign overflow_err = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_router_input_channel.sv
`default_nettype none

module tb_router_input_channel;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        polarity;
  logic        link_send_in;
  logic [63:0] link_data_in;
  logic        link_ready_out;
  logic        sw_req;
  logic [4:0]  sw_route;
  logic [63:0] sw_data;
  logic        sw_grant;
  logic        overflow_err;

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected contents of each VC, oldest first.
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic        ovf_exp = 1'b0;
  int          tag = 1;

`ifdef ROUTE_HOP_DEC_EN
  localparam logic [3:0] EXP_HX = 4'd1;
`else
  localparam logic [3:0] EXP_HX = 4'd2;
`endif

  router_input_channel #(.DATA_W(64), .DEPTH(DEPTH), .HOP_W(4)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .link_send_in(link_send_in), .link_data_in(link_data_in),
    .link_ready_out(link_ready_out), .sw_req(sw_req), .sw_route(sw_route),
    .sw_data(sw_data), .sw_grant(sw_grant), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] mk(input logic dx, input logic dy,
                                     input int hx, input int hy, input int pl);
    return {1'b0, dx, dy, 5'b0, 4'(hx), 4'(hy), 48'(pl)};
  endfunction

  function automatic logic [4:0] exp_route(input logic [63:0] p);
    if (p[55:52] != 4'd0) return p[62] ? 5'b01000 : 5'b00100;
    if (p[51:48] != 4'd0) return p[61] ? 5'b00010 : 5'b00001;
    return 5'b10000;
  endfunction

  function automatic logic [63:0] exp_data(input logic [63:0] p);
    logic [63:0] q;
    q = p;
`ifdef ROUTE_HOP_DEC_EN
    if (p[55:52] != 4'd0)      q[55:52] = p[55:52] - 4'd1;
    else if (p[51:48] != 4'd0) q[51:48] = p[51:48] - 4'd1;
`endif
    return q;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Compare every combinational output against the scoreboard.
  task automatic check_model(input string name);
    int wsz, rsz;
    logic [63:0] h;
    wsz = polarity ? q0.size() : q1.size();
    rsz = polarity ? q1.size() : q0.size();
    chk({name, "_ready"}, 64'(link_ready_out), 64'(wsz < DEPTH));
    chk({name, "_req"},   64'(sw_req),         64'(rsz > 0));
    chk({name, "_ovf"},   64'(overflow_err),   64'(ovf_exp));
    if (rsz > 0) begin
      h = polarity ? q1[0] : q0[0];
      chk({name, "_route"}, 64'(sw_route), 64'(exp_route(h)));
      chk({name, "_data"},  sw_data,       exp_data(h));
    end else begin
      chk({name, "_route0"}, 64'(sw_route), 64'd0);
    end
  endtask

  // One clock: drive at negedge, check, update model, clock, release.
  task automatic cycle(input string name, input logic pol, input logic send,
                       input logic [63:0] d, input logic grant);
    polarity = pol; link_send_in = send; link_data_in = d; sw_grant = grant;
    #1;
    check_model(name);
    if (pol) begin
      if (send) begin
        if (q0.size() < DEPTH) q0.push_back(d);
        else ovf_exp = 1'b1;
      end
      if (grant && q1.size() > 0) void'(q1.pop_front());
    end else begin
      if (send) begin
        if (q1.size() < DEPTH) q1.push_back(d);
        else ovf_exp = 1'b1;
      end
      if (grant && q0.size() > 0) void'(q0.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    link_send_in = 1'b0;
    sw_grant     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; link_send_in = 1'b0; sw_grant = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q0.delete(); q1.delete(); ovf_exp = 1'b0;
  endtask

  initial begin
    reset = 1'b1; polarity = 1'b1; link_send_in = 1'b0;
    link_data_in = '0; sw_grant = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset/idle state
    #1;
    chk("rst_ready", 64'(link_ready_out), 64'd1);
    chk("rst_req",   64'(sw_req),         64'd0);
    chk("rst_route", 64'(sw_route),       64'd0);
    chk("rst_ovf",   64'(overflow_err),   64'd0);
    chk("rst_data",  sw_data,             64'd0);

    // East route, hop count, single pop
    cycle("t2_push", 1'b1, 1'b1, mk(1'b0, 1'b0, 2, 0, 16'hA1), 1'b0);
    polarity = 1'b0; #1;
    chk("t2_req",   64'(sw_req),        64'd1);
    chk("t2_route", 64'(sw_route),      64'b00100);
    chk("t2_hx",    64'(sw_data[55:52]), 64'(EXP_HX));
    cycle("t2_pop", 1'b0, 1'b0, '0, 1'b1);
    #1;
    chk("t2_req_after", 64'(sw_req), 64'd0);

    // Fill VC0, overflow on third send
    cycle("t3_a", 1'b1, 1'b1, mk(1'b1, 1'b0, 3, 1, 16'hB1), 1'b0);
    cycle("t3_b", 1'b1, 1'b1, mk(1'b0, 1'b1, 0, 2, 16'hB2), 1'b0);
    #1;
    chk("t3_full", 64'(link_ready_out), 64'd0);
    cycle("t3_c", 1'b1, 1'b1, mk(1'b0, 1'b0, 0, 0, 16'hB3), 1'b0);
    #1;
    chk("t3_ovf", 64'(overflow_err), 64'd1);

    // Simultaneous push to VC1 and pop from VC0
    cycle("t4_both", 1'b0, 1'b1, mk(1'b0, 1'b0, 1, 1, 16'hC1), 1'b1);
    #1;
    chk("t4_vc0_left", 64'(sw_req),         64'd1);
    chk("t4_vc1_room", 64'(link_ready_out), 64'd1);
    cycle("t4_push2", 1'b0, 1'b1, mk(1'b0, 1'b0, 0, 5, 16'hC2), 1'b1);
    #1;
    chk("t4_vc1_full", 64'(link_ready_out), 64'd0);
    cycle("t4_drain0", 1'b1, 1'b0, '0, 1'b1);
    cycle("t4_drain1", 1'b1, 1'b0, '0, 1'b1);

    // Route cases: S and L via VC0, W via VC1
    cycle("t5_s", 1'b1, 1'b1, mk(1'b0, 1'b1, 0, 3, 16'hD1), 1'b0);
    cycle("t5_l", 1'b1, 1'b1, mk(1'b0, 1'b0, 0, 0, 16'hD2), 1'b0);
    polarity = 1'b0; #1;
    chk("t5_route_s", 64'(sw_route), 64'b00010);
    cycle("t5_pop_s", 1'b0, 1'b1, mk(1'b1, 1'b0, 1, 0, 16'hD3), 1'b1);
    #1;
    chk("t5_route_l", 64'(sw_route), 64'b10000);
    cycle("t5_pop_l", 1'b0, 1'b0, '0, 1'b1);
    polarity = 1'b1; #1;
    chk("t5_route_w", 64'(sw_route), 64'b01000);
    cycle("t5_pop_w", 1'b1, 1'b0, '0, 1'b1);

    // Fill / drain / refill each VC three times across pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        cycle("t6_fill0", 1'b1, 1'b1,
              mk(tag[0], tag[1], tag % 3, (tag / 3) % 4, 16'hE000 + tag), 1'b1);
        tag++;
      end
      for (int k = 0; k < DEPTH; k++) begin
        cycle("t6_fill1", 1'b0, 1'b1,
              mk(tag[1], tag[0], tag % 3, (tag / 3) % 4, 16'hE000 + tag), 1'b1);
        tag++;
      end
    end
    for (int k = 0; k < DEPTH; k++) cycle("t6_tail", 1'b1, 1'b0, '0, 1'b1);

    // Reset with VC0 full
    cycle("t7_a", 1'b1, 1'b1, mk(1'b0, 1'b0, 1, 0, 16'hF1), 1'b0);
    cycle("t7_b", 1'b1, 1'b1, mk(1'b0, 1'b0, 1, 0, 16'hF2), 1'b0);
    #1;
    chk("t7_full", 64'(link_ready_out), 64'd0);
    do_reset();
    polarity = 1'b1; #1;
    chk("t7_ready", 64'(link_ready_out), 64'd1);
    chk("t7_ovf",   64'(overflow_err),   64'd0);
    polarity = 1'b0; #1;
    chk("t7_req",   64'(sw_req),   64'd0);
    chk("t7_route", 64'(sw_route), 64'd0);
    chk("t7_data",  sw_data,       64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
